// File: rtl/l2_storage_pkg.sv
// Shared sizing constants for the L2 way storage slice.
package l2_storage_pkg;

  localparam int S_OFFSET  = 5;
  localparam int S_INDEX   = 3;
  localparam int S_TAG     = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_WAYS  = 4;
  localparam int LINE_BITS = 256;
  localparam int BYTES     = LINE_BITS / 8;

endpackage : l2_storage_pkg

// File: rtl/l2_meta_ram.sv
// Small resettable metadata array with one-cycle registered read and
// write-through forwarding of the value written on the same edge.
module l2_meta_ram #(
  parameter int WIDTH   = 1,
  parameter int S_INDEX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read,
  input  logic               load,
  input  logic [S_INDEX-1:0] rindex,
  input  logic [S_INDEX-1:0] windex,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  localparam int NUM_SETS = 2 ** S_INDEX;

  logic [WIDTH-1:0] mem [NUM_SETS];
  logic [WIDTH-1:0] rdata_p1;

  // Entry update and registered read; reset clears every entry and the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        mem[s] <= '0;
      end
      rdata_p1 <= '0;
    end else begin
      if (load) begin
        mem[windex] <= wdata;
      end
      if (read) begin
        rdata_p1 <= (load && (rindex == windex)) ? wdata : mem[rindex];
      end
    end
  end

  assign rdata = rdata_p1;

endmodule : l2_meta_ram

// File: rtl/l2_way_storage.sv
// Storage core of the 4-way L2: per-way valid/dirty/tag arrays, per-way
// byte-writable line arrays, and the line-fill buffer. No hit/LRU logic here.
module l2_way_storage
  import l2_storage_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_index  = S_INDEX,
  parameter int s_tag    = S_TAG,
  parameter int num_ways = NUM_WAYS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read,
  input  logic [s_index-1:0]           rindex,
  input  logic [s_index-1:0]           windex,
  input  logic [num_ways-1:0]          valid_load,
  input  logic [num_ways-1:0]          valid_in,
  input  logic [num_ways-1:0]          dirty_load,
  input  logic [num_ways-1:0]          dirty_in,
  input  logic [num_ways-1:0]          tag_load,
  input  logic [s_tag-1:0]             tag_in,
  input  logic [num_ways*(2**s_offset)-1:0] data_we,
  input  logic [num_ways*LINE_BITS-1:0]  data_in,
  input  logic                         buf_load,
  input  logic [LINE_BITS-1:0]         buf_in,
  output logic [num_ways-1:0]          valid_out,
  output logic [num_ways-1:0]          dirty_out,
  output logic [num_ways*s_tag-1:0]    tag_out,
  output logic [num_ways*LINE_BITS-1:0] data_out,
  output logic [LINE_BITS-1:0]         buf_out
);

  localparam int num_sets = 2 ** s_index;
  localparam int bytes    = 2 ** s_offset;

  // Per-byte select between the stored line and same-edge write data.
  function automatic logic [LINE_BITS-1:0] merge_bytes(
    input logic [LINE_BITS-1:0] stored,
    input logic [LINE_BITS-1:0] wdata,
    input logic [bytes-1:0]     we,
    input logic                 same_set
  );
    logic [LINE_BITS-1:0] line;
    line = stored;
    for (int i = 0; i < bytes; i++) begin
      if (same_set && we[i]) begin
        line[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return line;
  endfunction

  for (genvar w = 0; w < num_ways; w++) begin : g_way
    logic                 valid_q;
    logic                 dirty_q;
    logic [s_tag-1:0]     tag_q;
    logic [bytes-1:0]     we;
    logic [LINE_BITS-1:0] wdata;
    logic [LINE_BITS-1:0] line_mem [num_sets];
    logic [LINE_BITS-1:0] line_p1;

    l2_meta_ram #(.WIDTH(1), .S_INDEX(s_index)) u_valid (
      .clk    (clk),
      .rst    (rst),
      .read   (read),
      .load   (valid_load[w]),
      .rindex (rindex),
      .windex (windex),
      .wdata  (valid_in[w]),
      .rdata  (valid_q)
    );

    l2_meta_ram #(.WIDTH(1), .S_INDEX(s_index)) u_dirty (
      .clk    (clk),
      .rst    (rst),
      .read   (read),
      .load   (dirty_load[w]),
      .rindex (rindex),
      .windex (windex),
      .wdata  (dirty_in[w]),
      .rdata  (dirty_q)
    );

    l2_meta_ram #(.WIDTH(s_tag), .S_INDEX(s_index)) u_tag (
      .clk    (clk),
      .rst    (rst),
      .read   (read),
      .load   (tag_load[w]),
      .rindex (rindex),
      .windex (windex),
      .wdata  (tag_in),
      .rdata  (tag_q)
    );

    assign we    = data_we[w*bytes +: bytes];
    assign wdata = data_in[w*LINE_BITS +: LINE_BITS];

    // Byte-granular line write; contents survive reset like a RAM.
    always_ff @(posedge clk) begin
      for (int i = 0; i < bytes; i++) begin
        if (we[i]) begin
          line_mem[windex][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end

    // Registered line read with per-byte forwarding of same-edge writes.
    always_ff @(posedge clk) begin
      if (rst) begin
        line_p1 <= '0;
      end else if (read) begin
        line_p1 <= merge_bytes(line_mem[rindex], wdata, we, rindex == windex);
      end
    end

    assign valid_out[w]                     = valid_q;
    assign dirty_out[w]                     = dirty_q;
    assign tag_out[w*s_tag +: s_tag]        = tag_q;
    assign data_out[w*LINE_BITS +: LINE_BITS] = line_p1;
  end

  logic [LINE_BITS-1:0] buf_p1;

  // Line-fill buffer: captures pmem read data when loaded, else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_p1 <= '0;
    end else if (buf_load) begin
      buf_p1 <= buf_in;
    end
  end

  assign buf_out = buf_p1;

endmodule : l2_way_storage

// File: tb/tb_l2_way_storage.sv
// Scoreboard bench for l2_way_storage: expectations are queued when stimulus
// is driven and checked one edge later.
module tb_l2_way_storage;

  logic           clk = 1'b0;
  logic           rst;
  logic           read;
  logic [2:0]     rindex;
  logic [2:0]     windex;
  logic [3:0]     valid_load;
  logic [3:0]     valid_in;
  logic [3:0]     dirty_load;
  logic [3:0]     dirty_in;
  logic [3:0]     tag_load;
  logic [23:0]    tag_in;
  logic [127:0]   data_we;
  logic [1023:0]  data_in;
  logic           buf_load;
  logic [255:0]   buf_in;
  logic [3:0]     valid_out;
  logic [3:0]     dirty_out;
  logic [95:0]    tag_out;
  logic [1023:0]  data_out;
  logic [255:0]   buf_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           kind;   // 0 valid, 1 dirty, 2 tag, 3 data, 4 buf
    int           way;
    logic [255:0] val;
    string        name;
  } exp_t;

  exp_t sb[$];

  logic [23:0] m_tag   [4][8];
  logic        m_valid [4][8];

  l2_way_storage dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .rindex     (rindex),
    .windex     (windex),
    .valid_load (valid_load),
    .valid_in   (valid_in),
    .dirty_load (dirty_load),
    .dirty_in   (dirty_in),
    .tag_load   (tag_load),
    .tag_in     (tag_in),
    .data_we    (data_we),
    .data_in    (data_in),
    .buf_load   (buf_load),
    .buf_in     (buf_in),
    .valid_out  (valid_out),
    .dirty_out  (dirty_out),
    .tag_out    (tag_out),
    .data_out   (data_out),
    .buf_out    (buf_out)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] observed(input int kind, input int way);
    logic [255:0] v;
    v = '0;
    case (kind)
      0: v[3:0]  = valid_out;
      1: v[3:0]  = dirty_out;
      2: v[23:0] = tag_out[way*24 +: 24];
      3: v       = data_out[way*256 +: 256];
      default: v = buf_out;
    endcase
    return v;
  endfunction

  function automatic void push(input int kind, input int way,
                               input logic [255:0] val, input string name);
    exp_t e;
    e.kind = kind; e.way = way; e.val = val; e.name = name;
    sb.push_back(e);
  endfunction

  task automatic clear_ctrl();
    rst = 0; valid_load = 0; valid_in = 0; dirty_load = 0; dirty_in = 0;
    tag_load = 0; tag_in = 0; data_we = 0; data_in = 0; buf_load = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [255:0] obs;
    clear_ctrl();
    read = 1; rindex = 0; windex = 0; buf_in = 0;
    rst = 1;
    for (int w = 0; w < 4; w++) begin
      push(2, w, 256'h0, "reset_tag");
      push(3, w, 256'h0, "reset_data");
    end
    push(0, 0, 256'h0, "reset_valid");
    push(1, 0, 256'h0, "reset_dirty");
    push(4, 0, 256'h0, "reset_buf");
    step();
    rst = 0;
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 8; s++) begin
        m_tag[w][s] = 0; m_valid[w][s] = 0;
      end
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
  endtask

  task automatic test_tag_valid();
    exp_t e;
    logic [255:0] obs;
    clear_ctrl();
    read = 0; windex = 5;
    tag_load = 4'b0100; tag_in = 24'hABCDEF;
    valid_load = 4'b0100; valid_in = 4'b0100;
    dirty_load = 4'b0010; dirty_in = 4'b0010;
    step();
    clear_ctrl();
    read = 1; rindex = 5;
    push(2, 2, 256'hABCDEF, "tag_way2_set5");
    push(0, 0, 256'h4, "valid_set5");
    push(1, 0, 256'h2, "dirty_set5");
    push(2, 1, 256'h0, "tag_way1_set5");
    step();
    rindex = 4;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    push(0, 0, 256'h0, "valid_set4");
    push(2, 2, 256'h0, "tag_way2_set4");
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    m_tag[2][5] = 24'hABCDEF; m_valid[2][5] = 1;
  endtask

  task automatic test_forward();
    exp_t e;
    logic [255:0] obs;
    clear_ctrl();
    read = 0; windex = 3; tag_load = 4'b0001; tag_in = 24'h0AAAAA;
    step();
    clear_ctrl();
    read = 1; rindex = 3;
    push(2, 0, 256'h0AAAAA, "tag_old_value");
    step();
    windex = 3; tag_load = 4'b0001; tag_in = 24'h123456;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    push(2, 0, 256'h123456, "tag_forwarded");
    step();
    clear_ctrl();
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    m_tag[0][3] = 24'h123456;
  endtask

  task automatic test_byte_we();
    exp_t e;
    logic [255:0] obs;
    logic [255:0] merged;
    merged = {{28{8'h11}}, {4{8'hFF}}};
    clear_ctrl();
    read = 0; windex = 0;
    data_we[63:32] = 32'hFFFFFFFF;
    data_in[511:256] = {32{8'h11}};
    step();
    clear_ctrl();
    read = 1; rindex = 0; windex = 0;
    data_we[63:32] = 32'h0000000F;
    data_in[511:256] = {32{8'hFF}};
    push(3, 1, merged, "byte_we_forward");
    step();
    clear_ctrl();
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    push(3, 1, merged, "byte_we_stored");
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
  endtask

  task automatic test_hold_rst();
    exp_t e;
    logic [255:0] obs;
    clear_ctrl();
    read = 1; rindex = 5;
    step();
    read = 0; rindex = 4;
    windex = 5; valid_load = 4'b1000; valid_in = 4'b1000;
    push(0, 0, 256'h4, "hold_valid");
    push(2, 2, 256'hABCDEF, "hold_tag");
    step();
    clear_ctrl();
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    read = 1; rindex = 5;
    push(0, 0, 256'hC, "write_during_hold");
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    rst = 1; windex = 6; rindex = 6; valid_load = 4'hF; valid_in = 4'hF;
    push(0, 0, 256'h0, "rst_over_load_out");
    step();
    clear_ctrl();
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 8; s++) begin
        m_tag[w][s] = 0; m_valid[w][s] = 0;
      end
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    read = 1; rindex = 6;
    push(0, 0, 256'h0, "rst_over_load_entry");
    step();
    rindex = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    push(3, 1, {{28{8'h11}}, {4{8'hFF}}}, "data_survives_rst");
    push(0, 0, 256'h0, "valid_cleared_set0");
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
  endtask

  task automatic test_buffer();
    exp_t e;
    logic [255:0] obs;
    logic [255:0] pat;
    pat = {8{32'hDEADBEEF}};
    clear_ctrl();
    read = 0;
    buf_load = 1; buf_in = pat;
    push(4, 0, pat, "buf_load");
    step();
    buf_load = 0; buf_in = ~pat;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
      if (obs !== e.val) begin
        bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
      end
    end
    for (int c = 0; c < 2; c++) begin
      push(4, 0, pat, "buf_hold");
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
        if (obs !== e.val) begin
          bad++; $display("FAIL %s way%0d: got %h want %h", e.name, e.way, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [255:0] obs;
    logic [3:0]   vexp;
    int           ws, rs;
    clear_ctrl();
    read = 1;
    for (int c = 0; c < 40; c++) begin
      ws = $urandom_range(0, 7);
      rs = ($urandom_range(0, 2) == 0) ? ws : $urandom_range(0, 7);
      windex = ws[2:0]; rindex = rs[2:0];
      tag_load = 4'($urandom_range(0, 15));
      tag_in = 24'($urandom);
      valid_load = 4'($urandom_range(0, 15));
      valid_in = 4'($urandom_range(0, 15));
      vexp = 0;
      for (int w = 0; w < 4; w++) begin
        push(2, w, (tag_load[w] && rs == ws) ? 256'(tag_in) : 256'(m_tag[w][rs]),
             "b2b_tag");
        vexp[w] = (valid_load[w] && rs == ws) ? valid_in[w] : m_valid[w][rs];
      end
      push(0, 0, 256'(vexp), "b2b_valid");
      for (int w = 0; w < 4; w++) begin
        if (tag_load[w])   m_tag[w][ws]   = tag_in;
        if (valid_load[w]) m_valid[w][ws] = valid_in[w];
      end
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = observed(e.kind, e.way); total++;
        if (obs !== e.val) begin
          bad++; $display("FAIL %s way%0d cycle%0d: got %h want %h",
                          e.name, e.way, c, obs, e.val);
        end
      end
    end
    clear_ctrl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ctrl();
    read = 0; rindex = 0; windex = 0; buf_in = 0;
    @(negedge clk);
    test_reset();
    test_tag_valid();
    test_forward();
    test_byte_we();
    test_hold_rst();
    test_buffer();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_l2_way_storage
